// File: rtl/core_fetch_ctrl.sv
// Instruction fetch controller: sequences PC through boot, run, halt and pause,
// and holds the fetched word in the execute register.
module core_fetch_ctrl #(
   parameter int unsigned PC_W      = 15,
   parameter int unsigned INSTR_W   = 16,
   parameter int unsigned RESET_VEC = 0,
   parameter logic [3:0]  HLT_OPC   = 4'hF,
   parameter int unsigned STALL_W   = 8
) (
   input  logic               i_clk,
   input  logic               i_rstn,
   input  logic               i_smIsBooted,
   input  logic               i_smStartPause,
   input  logic [INSTR_W-1:0] i_memDataIn,
   input  logic               i_memReady,
   input  logic               i_redirEn,
   input  logic [PC_W-1:0]    i_redirAddr,
   output logic [PC_W:0]      o_memAddr,
   output logic               o_memRd,
   output logic [INSTR_W-1:0] o_instr,
   output logic               o_instrValid,
   output logic               o_smNowPaused,
   output logic [PC_W-1:0]    o_reportPC,
   output logic               o_reportHLT,
   output logic [STALL_W-1:0] o_stallCnt
);

   typedef enum logic [1:0] {BOOT, RUN, HALTED, PAUSED} fsmStateT;

   localparam logic [PC_W-1:0]    RESET_PC  = PC_W'(RESET_VEC);
   localparam logic [STALL_W-1:0] STALL_MAX = '1;

   fsmStateT            stateReg;
   fsmStateT            curState;
   logic [PC_W-1:0]     pcReg;
   logic [INSTR_W-1:0]  instrReg;
   logic                validReg;
   logic [STALL_W-1:0]  stallReg;
   logic                hltDetect;

   // A live halt opcode in the execute register turns RUN into HALTED in the
   // same cycle, so the fetch request drops before the next edge.
   assign hltDetect = validReg && (instrReg[INSTR_W-1 -: 4] == HLT_OPC);

   always_comb begin
      curState = stateReg;
      if (stateReg == RUN && hltDetect)
         curState = HALTED;
   end

   always_ff @(posedge i_clk or negedge i_rstn) begin
      if (!i_rstn) begin
         stateReg <= BOOT;
         pcReg    <= RESET_PC;
         instrReg <= '0;
         validReg <= 1'b0;
         stallReg <= '0;
      end else if (!i_smIsBooted) begin
         stateReg <= BOOT;
         pcReg    <= RESET_PC;
         instrReg <= '0;
         validReg <= 1'b0;
      end else begin
         case (curState)
            BOOT: stateReg <= RUN;
            RUN: begin
               if (i_smStartPause) begin
                  stateReg <= PAUSED;
                  instrReg <= '0;
                  validReg <= 1'b0;
               end else if (i_redirEn) begin
                  pcReg    <= i_redirAddr;
                  instrReg <= '0;
                  validReg <= 1'b0;
               end else if (i_memReady) begin
                  instrReg <= i_memDataIn;
                  validReg <= 1'b1;
                  pcReg    <= pcReg + 1'b1;
               end else begin
                  instrReg <= '0;
                  validReg <= 1'b0;
                  if (stallReg != STALL_MAX)
                     stallReg <= stallReg + 1'b1;
               end
            end
            HALTED: begin
               // Only a pause releases a halt; the halt word is dropped so
               // resume continues at the address after it.
               if (i_smStartPause) begin
                  stateReg <= PAUSED;
                  instrReg <= '0;
                  validReg <= 1'b0;
               end else begin
                  stateReg <= HALTED;
               end
            end
            PAUSED: begin
               if (!i_smStartPause)
                  stateReg <= RUN;
            end
            default: stateReg <= BOOT;
         endcase
      end
   end

   assign o_memAddr     = {1'b0, pcReg};
   assign o_memRd       = (curState == RUN);
   assign o_instr       = instrReg;
   assign o_instrValid  = validReg;
   assign o_smNowPaused = (stateReg == PAUSED);
   assign o_reportPC    = pcReg;
   assign o_reportHLT   = (curState == HALTED);
   assign o_stallCnt    = stallReg;

endmodule

// File: tb/tb_core_fetch_ctrl.sv
// Bench for core_fetch_ctrl: directed scenarios then random traffic, all
// checked against a rule-level reference model.
module tb_core_fetch_ctrl;

   logic        clk = 1'b0;
   logic        rstn;
   logic        booted, pause, ready, redir;
   logic [15:0] data;
   logic [14:0] raddr;

   logic [15:0] memAddr, instr;
   logic        memRd, instrValid, nowPaused, reportHLT;
   logic [14:0] reportPC;
   logic [7:0]  stallCnt;

   logic [15:0] sMemAddr, sInstr;
   logic        sMemRd, sInstrValid, sNowPaused, sReportHLT;
   logic [14:0] sReportPC;
   logic [1:0]  sStallCnt;

   int nCompared = 0;
   int nMismatched = 0;

   // Reference model: 0 = boot, 1 = run, 2 = paused; halt is derived.
   int          mState;
   int          mPc;
   logic [15:0] mInstr;
   bit          mValid;
   int          mStall;

   always #5 clk = ~clk;

   core_fetch_ctrl dut (
      .i_clk(clk), .i_rstn(rstn), .i_smIsBooted(booted), .i_smStartPause(pause),
      .i_memDataIn(data), .i_memReady(ready), .i_redirEn(redir), .i_redirAddr(raddr),
      .o_memAddr(memAddr), .o_memRd(memRd), .o_instr(instr), .o_instrValid(instrValid),
      .o_smNowPaused(nowPaused), .o_reportPC(reportPC), .o_reportHLT(reportHLT),
      .o_stallCnt(stallCnt)
   );

   core_fetch_ctrl #(.STALL_W(2)) dutSmall (
      .i_clk(clk), .i_rstn(rstn), .i_smIsBooted(booted), .i_smStartPause(pause),
      .i_memDataIn(data), .i_memReady(ready), .i_redirEn(redir), .i_redirAddr(raddr),
      .o_memAddr(sMemAddr), .o_memRd(sMemRd), .o_instr(sInstr), .o_instrValid(sInstrValid),
      .o_smNowPaused(sNowPaused), .o_reportPC(sReportPC), .o_reportHLT(sReportHLT),
      .o_stallCnt(sStallCnt)
   );

   task automatic checkVal(input string tag, input logic [31:0] got, input logic [31:0] exp);
      nCompared++;
      if (got !== exp) begin
         nMismatched++;
         $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
      end
   endtask

   function automatic bit modelHalted();
      return (mState == 1) && mValid && (mInstr[15:12] == 4'hF);
   endfunction

   task automatic modelReset();
      mState = 0; mPc = 0; mInstr = '0; mValid = 0; mStall = 0;
   endtask

   task automatic checkAll(input string tag);
      bit hlt;
      hlt = modelHalted();
      checkVal({tag, ".memAddr"}, 32'(memAddr), 32'(mPc));
      checkVal({tag, ".memRd"}, 32'(memRd), 32'(mState == 1 && !hlt));
      checkVal({tag, ".instr"}, 32'(instr), 32'(mInstr));
      checkVal({tag, ".valid"}, 32'(instrValid), 32'(mValid));
      checkVal({tag, ".paused"}, 32'(nowPaused), 32'(mState == 2));
      checkVal({tag, ".pc"}, 32'(reportPC), 32'(mPc));
      checkVal({tag, ".hlt"}, 32'(reportHLT), 32'(hlt));
      checkVal({tag, ".stall"}, 32'(stallCnt), 32'((mStall > 255) ? 255 : mStall));
      checkVal({tag, ".sStall"}, 32'(sStallCnt), 32'((mStall > 3) ? 3 : mStall));
      checkVal({tag, ".sPc"}, 32'(sMemAddr), 32'(mPc));
      checkVal({tag, ".sHlt"}, 32'(sReportHLT), 32'(hlt));
      checkVal({tag, ".sMisc"}, {28'd0, sMemRd, sInstrValid, sNowPaused, 1'b0},
               {28'd0, mState == 1 && !hlt, mValid, mState == 2, 1'b0});
      checkVal({tag, ".sInstr"}, 32'(sInstr), 32'(mInstr));
      checkVal({tag, ".sRepPc"}, 32'(sReportPC), 32'(mPc));
   endtask

   // One clock: apply the rules in priority order, then compare.
   task automatic tick(input string tag);
      bit hlt;
      @(posedge clk);
      hlt = modelHalted();
      if (!booted) begin
         mState = 0; mPc = 0; mInstr = '0; mValid = 0;
      end else if (mState == 0) begin
         mState = 1;
      end else if (mState == 2) begin
         if (!pause) mState = 1;
      end else if (pause) begin
         mState = 2; mInstr = '0; mValid = 0;
      end else if (hlt) begin
         // frozen
      end else if (redir) begin
         mPc = int'(raddr); mInstr = '0; mValid = 0;
      end else if (ready) begin
         mInstr = data; mValid = 1; mPc = (mPc + 1) % 32768;
      end else begin
         mInstr = '0; mValid = 0; mStall++;
      end
      #1;
      checkAll(tag);
   endtask

   task automatic asyncReset(input string tag);
      #2;
      rstn = 1'b0;
      #1;
      modelReset();
      checkAll(tag);
      @(negedge clk);
      rstn = 1'b1;
   endtask

   initial begin
      rstn = 1'b0; booted = 0; pause = 0; ready = 0; redir = 0; data = '0; raddr = '0;
      modelReset();
      #3;
      checkAll("reset");
      @(negedge clk);
      rstn = 1'b1; booted = 1; ready = 1; data = 16'h1234;

      // Boot then fetch
      tick("boot");
      checkVal("bootAddr0", 32'(memAddr), 32'h0000);
      tick("fetch0");
      checkVal("fetchAddr1", 32'(memAddr), 32'h0001);
      checkVal("fetchInstr", 32'(instr), 32'h1234);
      checkVal("fetchValid", 32'(instrValid), 32'd1);

      // Wait states at PC=5
      redir = 1; raddr = 15'h5; tick("redir5");
      redir = 0; ready = 0;
      for (int i = 0; i < 3; i++) tick("stall");
      checkVal("stallPc", 32'(reportPC), 32'd5);
      checkVal("stallCnt3", 32'(stallCnt), 32'd3);
      checkVal("stallValid", 32'(instrValid), 32'd0);
      for (int i = 0; i < 2; i++) tick("stall");
      checkVal("stallSat", 32'(sStallCnt), 32'd3);

      // Redirect wins over fetch
      redir = 1; raddr = 15'h10; tick("redir10");
      raddr = 15'h200; ready = 1; tick("redirVsFetch");
      checkVal("redirPc", 32'(reportPC), 32'h200);
      checkVal("redirValid", 32'(instrValid), 32'd0);

      // Halt, ignored redirect, pause, resume
      raddr = 15'h7; ready = 0; tick("redir7");
      redir = 0; ready = 1; data = 16'hF000; tick("fetchHlt");
      checkVal("hltFlag", 32'(reportHLT), 32'd1);
      checkVal("hltPc", 32'(reportPC), 32'd8);
      checkVal("hltMemRd", 32'(memRd), 32'd0);
      redir = 1; raddr = 15'h55; tick("hltRedir");
      checkVal("hltRedirPc", 32'(reportPC), 32'd8);
      redir = 0; pause = 1;
      for (int i = 0; i < 2; i++) begin
         tick("pause");
         checkVal("pausedFlag", 32'(nowPaused), 32'd1);
         checkVal("pausedHlt", 32'(reportHLT), 32'd0);
      end
      pause = 0; data = 16'h0123; tick("resume");
      checkVal("resumeAddr", 32'(memAddr), 32'h0008);
      checkVal("resumeRd", 32'(memRd), 32'd1);

      // PC wrap
      redir = 1; raddr = 15'h7FFF; tick("redirTop");
      redir = 0; tick("wrap");
      checkVal("wrapPc", 32'(reportPC), 32'd0);

      // Async reset mid-pause
      pause = 1; tick("pauseForReset");
      asyncReset("arstPause");
      checkVal("arstPc", 32'(reportPC), 32'd0);
      pause = 0;

      // Random traffic
      for (int n = 0; n < 600; n++) begin
         booted = ($urandom_range(99) < 96);
         pause  = ($urandom_range(99) < 10);
         redir  = ($urandom_range(99) < 15);
         ready  = ($urandom_range(99) < 70);
         data   = 16'($urandom);
         raddr  = 15'($urandom);
         if ($urandom_range(49) == 0) asyncReset("arstRand");
         else tick("rand");
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCompared, nMismatched);
      $finish;
   end

endmodule
